// File: rtl/operand_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : operand_loader_pkg
//  Purpose  : State encoding and frame byte-slot constants for operand_loader.
//  Revision : 1.0
// ============================================================================
package operand_loader_pkg;

  typedef logic [2:0] state_t;

  localparam state_t LD0  = 3'd0;
  localparam state_t LD1  = 3'd1;
  localparam state_t LD2  = 3'd2;
  localparam state_t LD3  = 3'd3;
  localparam state_t LD4  = 3'd4;
  localparam state_t HOLD = 3'd5;

  localparam int FRAME_BYTES = 5;

  // Load state LDn fills byte slot n of the frame.
  localparam int SLOT_A_HI = 0;
  localparam int SLOT_A_LO = 1;
  localparam int SLOT_B_HI = 2;
  localparam int SLOT_B_LO = 3;
  localparam int SLOT_C    = 4;

endpackage
`default_nettype wire

// File: rtl/operand_loader.sv
`default_nettype none
// ============================================================================
//  Module   : operand_loader
//  Purpose  : Assembles a/b/c from a byte stream and commits them atomically,
//             then holds en high for HOLD_CYCLES cycles.
//  Revision : 1.0
// ============================================================================
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int HOLD_CYCLES = 1,
  parameter int FCW         = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     din,
  input  logic           din_valid,
  input  logic           din_sof,
  output logic           din_ready,
  output logic [15:0]    a,
  output logic [15:0]    b,
  output logic [7:0]     c,
  output logic           en,
  output logic [FCW-1:0] frame_cnt,
  output logic           sof_err
);

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
    $error("operand_loader: HOLD_CYCLES must be in 1..15");
  end

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);
  localparam state_t     LAST_LD   = state_t'(FRAME_BYTES - 1);

  state_t         state_q, state_d;
  logic [15:0]    sa_q, sa_d;
  logic [15:0]    sb_q, sb_d;
  logic [15:0]    a_q, a_d;
  logic [15:0]    b_q, b_d;
  logic [7:0]     c_q, c_d;
  logic           en_q, en_d;
  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
  logic           sof_err_q, sof_err_d;
  logic [3:0]     hold_q, hold_d;
  logic           accept;

  assign din_ready = !rst && (state_q != HOLD);
  assign accept    = din_valid && din_ready;

  always_comb begin
    state_d     = state_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    en_d        = en_q;
    frame_cnt_d = frame_cnt_q;
    sof_err_d   = 1'b0;
    hold_d      = hold_q;

    case (state_q)
      HOLD: begin
        if (hold_q == 4'd0) begin
          en_d    = 1'b0;
          state_d = LD0;
        end else begin
          hold_d = hold_q - 4'd1;
        end
      end
      LD0: begin
        if (accept) begin
          if (din_sof) begin
            sa_d[15:8] = din;
            state_d    = LD1;
          end else begin
            sof_err_d = 1'b1;
          end
        end
      end
      LD1, LD2, LD3, LD4: begin
        if (accept) begin
          // A fresh SOF mid-frame restarts with this byte as byte 0.
          if (din_sof) begin
            sa_d[15:8] = din;
            state_d    = LD1;
            sof_err_d  = 1'b1;
          end else if (state_q == LAST_LD) begin
            a_d         = sa_q;
            b_d         = sb_q;
            c_d         = din;
            en_d        = 1'b1;
            frame_cnt_d = frame_cnt_q + FCW'(1);
            hold_d      = HOLD_LOAD;
            state_d     = HOLD;
          end else begin
            case (int'(state_q))
              SLOT_A_LO: sa_d[7:0]  = din;
              SLOT_B_HI: sb_d[15:8] = din;
              SLOT_B_LO: sb_d[7:0]  = din;
              default:   sa_d       = sa_q;
            endcase
            state_d = state_q + 3'd1;
          end
        end
      end
      default: state_d = LD0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LD0;
      sa_q        <= '0;
      sb_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      en_q        <= 1'b0;
      frame_cnt_q <= '0;
      sof_err_q   <= 1'b0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      en_q        <= en_d;
      frame_cnt_q <= frame_cnt_d;
      sof_err_q   <= sof_err_d;
      hold_q      <= hold_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign c         = c_q;
  assign en        = en_q;
  assign frame_cnt = frame_cnt_q;
  assign sof_err   = sof_err_q;

endmodule
`default_nettype wire

// File: tb/tb_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_operand_loader
//  Purpose  : Directed bench for operand_loader (HOLD_CYCLES=1 and 3) with a
//             frame-level reference model and hand-computed literal checks.
//  Revision : 1.0
// ============================================================================
module tb_operand_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] din1, din3;
  logic       v1, v3, s1, s3;

  logic        ready1, ready3, en1, en3, err1, err3;
  logic [15:0] a1, b1, a3, b3;
  logic [7:0]  c1, c3, fc1, fc3;

  operand_loader #(.HOLD_CYCLES(1), .FCW(8)) dut1 (
    .clk(clk), .rst(rst), .din(din1), .din_valid(v1), .din_sof(s1),
    .din_ready(ready1), .a(a1), .b(b1), .c(c1), .en(en1),
    .frame_cnt(fc1), .sof_err(err1)
  );

  operand_loader #(.HOLD_CYCLES(3), .FCW(8)) dut3 (
    .clk(clk), .rst(rst), .din(din3), .din_valid(v3), .din_sof(s3),
    .din_ready(ready3), .a(a3), .b(b3), .c(c3), .en(en3),
    .frame_cnt(fc3), .sof_err(err3)
  );

  // Frame-level model: bytes collected so far, cycles of hold remaining.
  typedef struct packed {
    logic [2:0]      nbytes;
    logic [3:0][7:0] by;
    logic [4:0]      hold_left;
    logic [15:0]     a;
    logic [15:0]     b;
    logic [7:0]      c;
    logic            en;
    logic [7:0]      fc;
    logic            err;
  } mdl_t;

  mdl_t m1, m3;
  int   total = 0;
  int   bad   = 0;
  bit   run   = 0;

  function automatic mdl_t step(mdl_t m, int hold, logic r, logic [7:0] d,
                                logic v, logic s);
    mdl_t n;
    n = m;
    n.err = 1'b0;
    if (r) begin
      n = '0;
    end else if (m.hold_left != 0) begin
      n.hold_left = m.hold_left - 5'd1;
      if (n.hold_left == 0) n.en = 1'b0;
    end else if (v) begin
      if (s) begin
        n.by[0]  = d;
        n.nbytes = 3'd1;
        n.err    = (m.nbytes != 0);
      end else if (m.nbytes == 0) begin
        n.err = 1'b1;
      end else if (m.nbytes == 4) begin
        n.a         = {m.by[0], m.by[1]};
        n.b         = {m.by[2], m.by[3]};
        n.c         = d;
        n.en        = 1'b1;
        n.fc        = m.fc + 8'd1;
        n.hold_left = 5'(hold);
        n.nbytes    = 3'd0;
      end else begin
        n.by[m.nbytes] = d;
        n.nbytes       = m.nbytes + 3'd1;
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m1 = step(m1, 1, rst, din1, v1, s1);
    m3 = step(m3, 3, rst, din3, v3, s3);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      chk("ready1", {31'd0, ready1}, {31'd0, !rst && m1.hold_left == 0});
      chk("a1", {16'd0, a1}, {16'd0, m1.a});
      chk("b1", {16'd0, b1}, {16'd0, m1.b});
      chk("c1", {24'd0, c1}, {24'd0, m1.c});
      chk("en1", {31'd0, en1}, {31'd0, m1.en});
      chk("fc1", {24'd0, fc1}, {24'd0, m1.fc});
      chk("err1", {31'd0, err1}, {31'd0, m1.err});
      chk("ready3", {31'd0, ready3}, {31'd0, !rst && m3.hold_left == 0});
      chk("a3", {16'd0, a3}, {16'd0, m3.a});
      chk("b3", {16'd0, b3}, {16'd0, m3.b});
      chk("c3", {24'd0, c3}, {24'd0, m3.c});
      chk("en3", {31'd0, en3}, {31'd0, m3.en});
      chk("fc3", {24'd0, fc3}, {24'd0, m3.fc});
      chk("err3", {31'd0, err3}, {31'd0, m3.err});
    end
  end

  // Presents a byte and waits (bounded) for the model to say it was taken.
  task automatic send(input int t, input logic [7:0] d, input logic s);
    logic acc, acc_now;
    acc = 1'b0;
    if (t == 1) begin din1 = d; s1 = s; v1 = 1'b1; end
    else        begin din3 = d; s3 = s; v3 = 1'b1; end
    for (int k = 0; k < 40 && !acc; k++) begin
      acc_now = !rst && ((t == 1) ? (m1.hold_left == 0) : (m3.hold_left == 0));
      @(posedge clk);
      #1;
      acc = acc_now;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout actual=notaccepted required=accepted byte=%0h", d);
    end
  endtask

  task automatic idle(input int t);
    if (t == 1) v1 = 1'b0;
    else        v3 = 1'b0;
  endtask

  initial begin
    m1 = '0; m3 = '0;
    rst = 1'b1;
    din1 = 8'h00; v1 = 1'b0; s1 = 1'b0;
    din3 = 8'h00; v3 = 1'b0; s3 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_ready1", {31'd0, ready1}, 32'd0);
    chk("rst_a1", {16'd0, a1}, 32'd0);
    chk("rst_en1", {31'd0, en1}, 32'd0);
    chk("rst_fc1", {24'd0, fc1}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    run = 1'b1;

    // Basic frame, HOLD_CYCLES=1
    send(1, 8'hAB, 1); send(1, 8'hCD, 0); send(1, 8'h12, 0);
    send(1, 8'h34, 0); send(1, 8'h5A, 0);
    idle(1);
    @(negedge clk);
    chk("t1_a", {16'd0, a1}, 32'hABCD);
    chk("t1_b", {16'd0, b1}, 32'h1234);
    chk("t1_c", {24'd0, c1}, 32'h5A);
    chk("t1_en", {31'd0, en1}, 32'd1);
    chk("t1_fc", {24'd0, fc1}, 32'd1);
    chk("t1_ready", {31'd0, ready1}, 32'd0);
    @(negedge clk);
    chk("t1_en_fall", {31'd0, en1}, 32'd0);
    chk("t1_ready_back", {31'd0, ready1}, 32'd1);

    // Missing SOF in LD0
    send(1, 8'h11, 0);
    idle(1);
    @(negedge clk);
    chk("t3_err", {31'd0, err1}, 32'd1);
    chk("t3_a", {16'd0, a1}, 32'hABCD);
    @(negedge clk);
    chk("t3_err_clr", {31'd0, err1}, 32'd0);

    // SOF restart mid-frame
    send(1, 8'hAA, 1); send(1, 8'hBB, 0); send(1, 8'hCC, 1);
    @(negedge clk);
    chk("t4_err", {31'd0, err1}, 32'd1);
    send(1, 8'hDD, 0); send(1, 8'h01, 0); send(1, 8'h02, 0); send(1, 8'h03, 0);
    idle(1);
    @(negedge clk);
    chk("t4_a", {16'd0, a1}, 32'hCCDD);
    chk("t4_b", {16'd0, b1}, 32'h0102);
    chk("t4_c", {24'd0, c1}, 32'h03);
    chk("t4_fc", {24'd0, fc1}, 32'd2);

    // HOLD_CYCLES=3 with valid held through the hold window
    send(3, 8'hAB, 1); send(3, 8'hCD, 0); send(3, 8'h12, 0);
    send(3, 8'h34, 0); send(3, 8'h5A, 0);
    din3 = 8'h77; s3 = 1'b1; v3 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t2_en_hold", {31'd0, en3}, 32'd1);
      chk("t2_ready_hold", {31'd0, ready3}, 32'd0);
    end
    @(negedge clk);
    chk("t2_en_fall", {31'd0, en3}, 32'd0);
    chk("t2_ready_back", {31'd0, ready3}, 32'd1);
    send(3, 8'h77, 1); send(3, 8'h88, 0); send(3, 8'h99, 0);
    send(3, 8'hAA, 0); send(3, 8'hBB, 0);
    idle(3);
    @(negedge clk);
    chk("t2_a", {16'd0, a3}, 32'h7788);
    chk("t2_b", {16'd0, b3}, 32'h99AA);
    chk("t2_c", {24'd0, c3}, 32'hBB);
    chk("t2_fc", {24'd0, fc3}, 32'd2);

    // Reset in the middle of a frame
    send(1, 8'h01, 1); send(1, 8'h02, 0); send(1, 8'h03, 0);
    idle(1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    send(1, 8'h00, 1); send(1, 8'hFF, 0); send(1, 8'h80, 0);
    send(1, 8'h7F, 0); send(1, 8'h0F, 0);
    idle(1);
    @(negedge clk);
    chk("t5_a", {16'd0, a1}, 32'h00FF);
    chk("t5_b", {16'd0, b1}, 32'h807F);
    chk("t5_c", {24'd0, c1}, 32'h0F);
    chk("t5_fc", {24'd0, fc1}, 32'd1);

    // 256 back-to-back frames: counter wraps
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] x;
      x = 8'(i);
      send(1, x, 1); send(1, x ^ 8'h3C, 0); send(1, ~x, 0);
      send(1, x + 8'd7, 0); send(1, x ^ 8'hA5, 0);
      if (i == 254) begin
        @(negedge clk);
        chk("t6_fc255", {24'd0, fc1}, 32'd255);
      end
    end
    idle(1);
    @(negedge clk);
    chk("t6_fc_wrap", {24'd0, fc1}, 32'd0);
    chk("t6_c", {24'd0, c1}, 32'h5A);

    repeat (3) @(negedge clk);
    run = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/operand_loader.md
Name: operand_loader

Overview:
- Byte-serial front end for the bitwise/compare datapath stage: assembles operands a[15:0], b[15:0] and c[7:0] from an 8-bit valid/ready stream.
- Updates all three operands atomically, then asserts en for a fixed number of cycles.
- The downstream stage is event-driven on a/b, so a partially loaded operand must never appear on the outputs.

Parameters:
- HOLD_CYCLES, 1: number of cycles en stays high per frame. Legal range is 1..15; 0 is illegal and is caught by an elaboration assertion.
- FCW, 8: width of the frame counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- din  in  8  stream byte
- din_valid  in  1  din is valid this cycle
- din_sof  in  1  marks the first byte of a frame
- din_ready  out  1  loader can accept a byte this cycle
- a  out  16  operand a, registered
- b  out  16  operand b, registered
- c  out  8  operand c, registered
- en  out  1  operands valid and enabled for the downstream stage
- frame_cnt  out  FCW  count of completed frames; wraps
- sof_err  out  1  one-cycle pulse on a framing error

Behaviour:
- Reset values: a=0, b=0, c=0, en=0, frame_cnt=0, sof_err=0, state=LD0, shadow registers=0.
- din_ready is 0 while rst is high.
- Reset asserted mid-frame or mid-hold discards the partial shadow contents and forces en=0 on the next edge.
- A byte is accepted on a rising edge where din_valid=1 and din_ready=1.
- din_ready = 1 in states LD0..LD4 and 0 in state HOLD. It is a combinational decode of the state, gated by rst.
- Frame byte order:
  - LD0 loads sa[15:8]
  - LD1 loads sa[7:0]
  - LD2 loads sb[15:8]
  - LD3 loads sb[7:0]
  - LD4 loads sc
  - sa/sb/sc are internal shadow registers; a/b/c never change while loading.
- Transitions:
  - LD0 -> LD1 -> LD2 -> LD3 -> LD4, each on an accepted byte.
  - LD4 -> HOLD on an accepted byte.
  - HOLD -> LD0 after HOLD_CYCLES cycles.
  - With no accepted byte, the state holds.
- SOF rules:
  - In LD0, an accepted byte with din_sof=0 is dropped; state stays LD0; sof_err pulses.
  - In LD1..LD4, an accepted byte with din_sof=1 restarts the frame: the byte is stored as byte 0 (sa[15:8]), state goes to LD1, sof_err pulses.
  - In LD1..LD4, din_sof=0 is the normal case.
- Commit edge: the edge that accepts the LD4 byte loads a<=sa, b<=sb, c<=din, sets en<=1 and increments frame_cnt. Consequences:
  - a/b/c/en are visible in the cycle after the last byte is accepted (latency 1 cycle).
  - All three operands change on the same edge.
- HOLD:
  - en stays 1 for exactly HOLD_CYCLES cycles; din_ready=0 throughout.
  - On exit, en<=0 and state<=LD0.
  - a/b/c keep their last values until the next commit.
- din_valid asserted during HOLD is ignored (not accepted, no error). The upstream must keep the byte stable until it sees ready.
- frame_cnt increments modulo 2^FCW, e.g. 255 -> 0 with FCW=8.
- sof_err is registered and lasts one cycle per offending byte. Back-to-back errors produce back-to-back pulses.
- The hold counter is 4 bits wide and loads HOLD_CYCLES-1 at commit.

Decomposition:
- Package operand_loader_pkg holds:
  - the state enum {LD0, LD1, LD2, LD3, LD4, HOLD}
  - FRAME_BYTES=5
  - the per-state byte-slot constants
- No sub-module: the FSM, shadow registers and hold counter are small enough to stay in one module.

Test Plan:
1. Reset, then stream 0xAB(sof), 0xCD, 0x12, 0x34, 0x5A with continuous valid -> one cycle after the 5th accept: a=0xABCD, b=0x1234, c=0x5A, en=1 for 1 cycle, frame_cnt=1, din_ready=0 during that cycle.
2. HOLD_CYCLES=3, same frame, then valid held high with the next frame's bytes -> en high exactly 3 cycles; no byte accepted during HOLD; the first byte of the next frame is accepted in the cycle en falls.
3. Send 0x11 with sof=0 in LD0 -> byte dropped, sof_err=1 for one cycle, a/b/c unchanged, state remains LD0.
4. Send 0xAA(sof), 0xBB, then 0xCC(sof), 0xDD, 0x01, 0x02, 0x03 -> sof_err pulses on 0xCC; commit gives a=0xCCDD, b=0x0102, c=0x03.
5. Send 3 bytes of a frame, assert rst for 1 cycle, then a full frame 0x00, 0xFF, 0x80, 0x7F, 0x0F -> no commit from the partial frame; a=0x00FF, b=0x807F, c=0x0F; frame_cnt=1.
6. FCW=8, stream 256 back-to-back frames -> frame_cnt reads 255 after frame 255 and 0 after frame 256; a/b/c are never observed changing while en=0 inside a frame.
